dma_port_arbiter: RTL
=====================

Name: dma_port_arbiter

Overview:
- Shares the single DMA memory port between the convolution datapath requesters: load_block reads, previous-partial-sum reads and result write-back.
- Replaces ad-hoc combinational OR/mux glue with a registered round-robin arbiter.
- Grants are locked for the length of a transaction, so a multi-cycle block load is never interleaved with a write.
- Sits between convolution_layer/load_block and DMA.

Parameters:
NUM_REQ, 3, number of requesters (0 = block load, 1 = prev-data load, 2 = write-back)
ADDR_W, 16, DMA address width
DATA_W, 16, DMA write-data width
MAX_BURST, 8, maximum granted cycles per tenure (used only with ARB_BURST_LIMIT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request, held high for the whole transaction
req_rw  in  NUM_REQ  per-requester direction, 1 = read, 0 = write (DMA RW convention)
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
gnt  out  NUM_REQ  one-hot grant, registered
dmaEnable  out  1  DMA enable
rw  out  1  DMA direction
address  out  ADDR_W  DMA address
inputData  out  DATA_W  DMA write data
owner  out  $clog2(NUM_REQ)  index of current grantee, valid while busy
busy  out  1  high while a grant is held

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset).
- Reset values: gnt=0, busy=0, owner=0, dmaEnable=0, rw=0, address=0, inputData=0. Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-tenure drops the grant on the next edge. No DMA access is issued in the reset cycle.
- FSM states: IDLE, GRANT.
- IDLE, any req high at an edge:
  - Select the first requester scanning last+1, last+2, ... modulo NUM_REQ.
  - At that edge: gnt[sel]=1, owner=sel, busy=1, last=sel, state goes to GRANT.
  - Latency: gnt rises 1 cycle after req is first sampled high.
- IDLE, no req: stay in IDLE.
- GRANT, DMA-side outputs:
  - Combinational mux of the owner's inputs: dmaEnable=req[owner], rw=req_rw[owner], address=req_addr[owner], inputData=req_wdata[owner].
  - The owner may change address and data every cycle (burst stepping).
- Outside GRANT: dmaEnable=0, and address/rw/inputData are held at 0.
- GRANT exit: at an edge where req[owner]=0, clear gnt and busy and return to IDLE. Non-owner requests are ignored during GRANT.
- Turnaround: at least one IDLE cycle between tenures. Back-to-back grants are never issued in consecutive cycles.
- Simultaneous requests: round-robin only. A requester that just released has lowest priority at the next arbitration.
- Single requester: may be re-granted repeatedly, with one idle cycle between tenures.
- Requester rule: a requester must not drop req before gnt is seen. If it does, the grant is still issued and is released on the following edge.
- gnt is always one-hot or zero. Any other value is an assertion failure.

Optional Feature:
ARB_BURST_LIMIT_EN
- Defined:
  - A tenure counter counts granted cycles.
  - On reaching MAX_BURST with any other req pending, the grant is forcibly released at that edge (state goes to IDLE) and normal round-robin follows.
  - The preempted requester keeps req high and competes again.
  - With no other request pending, the tenure continues and the counter saturates.
- Undefined: tenures are unbounded. The counter is not built.

Test Plan:
- Reset, then req=3'b001 held 4 cycles -> gnt=001 one cycle later. dmaEnable=1 with address tracking req_addr[0] (500, 501, 502). Drop req -> gnt=000 on the next edge.
- req=3'b111 asserted together from reset -> grant order 0, 1, 2, 0, each tenure separated by one idle cycle. gnt is never multi-hot.
- Owner 2 writing (rw=0, addr=0x0040, data=0x1234) while req0 rises -> DMA stays on requester 2 until it releases; requester 0 is granted afterwards.
- reset asserted mid-GRANT -> next edge gnt=0, dmaEnable=0, busy=0. The first post-reset grant goes to requester 0 when req=3'b101.
- ARB_BURST_LIMIT_EN, MAX_BURST=8: req0 held 20 cycles, req1 raised at cycle 3 -> req0 released after 8 granted cycles, idle cycle, then req1 is granted. Without the macro, req0 keeps the port for all 20 cycles.
- Single requester re-requesting immediately -> re-granted after exactly one idle cycle.

Source files
------------

// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: registered round-robin owner of the single DMA port.
// Requesters: 0 = block load, 1 = prev-data load, 2 = write-back.
// A grant is locked until the owner drops req, so bursts are never interleaved.
// Optional macro ARB_BURST_LIMIT_EN caps a tenure at MAX_BURST granted cycles
// whenever another requester is waiting.
module dma_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  localparam int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      dmaEnable,
  output logic                      rw,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         inputData,
  output logic [OWN_W-1:0]          owner,
  output logic                      busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic [OWN_W-1:0]   owner_next;
  logic               busy_next;
  logic [OWN_W-1:0]   last, last_next;
  logic [OWN_W-1:0]   sel;
  logic [OWN_W-1:0]   cand;
  logic               found;
  logic               release_now;
  int                 idx;

`ifdef ARB_BURST_LIMIT_EN
  localparam int             CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             others_pending;
`endif

  // Round-robin pick: first pending requester after the last grantee
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(last) + i) % NUM_REQ;
      cand = OWN_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state logic: acquire from IDLE, hold in GRANT until the owner lets go
  always_comb begin
    state_next  = state;
    gnt_next    = gnt;
    owner_next  = owner;
    busy_next   = busy;
    last_next   = last;
    release_now = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
    cnt_next       = cnt;
    others_pending = |(req & ~gnt);
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_next    = GRANT;
          gnt_next      = '0;
          gnt_next[sel] = 1'b1;
          owner_next    = sel;
          busy_next     = 1'b1;
          last_next     = sel;
`ifdef ARB_BURST_LIMIT_EN
          cnt_next      = CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          release_now = 1'b1;
        end
`ifdef ARB_BURST_LIMIT_EN
        else if (cnt == CNT_MAX && others_pending) begin
          release_now = 1'b1;
        end
        else if (cnt != CNT_MAX) begin
          cnt_next = cnt + 1'b1;
        end
`endif
        if (release_now) begin
          state_next = IDLE;
          gnt_next   = '0;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and grant registers; reset leaves requester 0 first in line
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      busy  <= 1'b0;
      last  <= OWN_W'(NUM_REQ - 1);
`ifdef ARB_BURST_LIMIT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      owner <= owner_next;
      busy  <= busy_next;
      last  <= last_next;
`ifdef ARB_BURST_LIMIT_EN
      cnt   <= cnt_next;
`endif
    end
  end

  // DMA side follows the owner live so it can step address/data every cycle
  always_comb begin
    dmaEnable = 1'b0;
    rw        = 1'b0;
    address   = '0;
    inputData = '0;
    if (state == GRANT && !reset) begin
      dmaEnable = req[owner];
      rw        = req_rw[owner];
      address   = req_addr[int'(owner)*ADDR_W +: ADDR_W];
      inputData = req_wdata[int'(owner)*DATA_W +: DATA_W];
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_burst_cfg   : assert property (@(posedge clk) MAX_BURST >= 1);

endmodule
